// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path: FSM states, the widest
// frame, frame-length and parity helpers.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2
    } state_t;

    localparam int MAX_FRAME_BITS = 10;

    // Bits after the start bit: data (7/8) + optional parity + one stop.
    function automatic logic [3:0] frame_len(input logic eight, input logic pen);
        return 4'd8 + {3'd0, eight} + {3'd0, pen};
    endfunction

    function automatic logic odd_ones(input logic [7:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-time and bit counters for the receiver; strobes mid-bit sample points
// (btu) and the final sample of the frame (done).
module uart_bit_timer
    import uart_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  state_t      i_state,
    input  logic [18:0] i_k,
    input  logic [3:0]  i_n,
    output logic        o_btu,
    output logic        o_done
);

    logic [18:0] r_bit_time;
    logic [3:0]  r_bit_cnt;
    logic [18:0] w_limit;

    // Sample-point decode: half a bit in START to hit mid-start, a full bit in DATA.
    always_comb begin
        w_limit = 19'd0;
        o_btu   = 1'b0;
        case (i_state)
            START: begin
                w_limit = (i_k >> 1) - 19'd1;
                o_btu   = (r_bit_time == w_limit);
            end
            DATA: begin
                w_limit = i_k - 19'd1;
                o_btu   = (r_bit_time == w_limit);
            end
            default: begin
                w_limit = 19'd0;
                o_btu   = 1'b0;
            end
        endcase
        o_done = (i_state == DATA) && o_btu && (r_bit_cnt == (i_n - 4'd1));
    end

    // Counters: bit-time restarts at every sample point, bit count lives only in DATA.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit_time <= 19'd0;
            r_bit_cnt  <= 4'd0;
        end else begin
            if ((i_state == IDLE) || o_btu) begin
                r_bit_time <= 19'd0;
            end else begin
                r_bit_time <= r_bit_time + 19'd1;
            end
            if ((i_state != DATA) || o_done) begin
                r_bit_cnt <= 4'd0;
            end else if (o_btu) begin
                r_bit_cnt <= r_bit_cnt + 4'd1;
            end else begin
                r_bit_cnt <= r_bit_cnt;
            end
        end
    end

endmodule

// File: rtl/uart_receive.sv
// UART receiver: detects the start bit, deserializes one frame at a run-time
// bit rate and presents data plus sticky status flags to the host.
module uart_receive
    import uart_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [18:0] k,
    input  logic        EIGHT,
    input  logic        PEN,
    input  logic        OHEL,
    input  logic        RX,
    input  logic        READ,
    output logic        RX_RDY,
    output logic [7:0]  RX_DATA,
    output logic        PERR,
    output logic        FERR,
    output logic        OVF
);

    state_t                    r_state;
    logic [18:0]               r_k;
    logic                      r_eight;
    logic                      r_pen;
    logic                      r_ohel;
    logic [MAX_FRAME_BITS-1:0] r_shift;
    logic                      r_done;

    logic [3:0] w_n;
    logic       w_btu;
    logic       w_done;
    logic [7:0] w_data8;
    logic [7:0] w_data;
    logic       w_par_bit;
    logic       w_stop;
    logic       w_perr;

    assign w_n = frame_len(r_eight, r_pen);

    uart_bit_timer u_timer (
        .i_clk   (clk),
        .i_reset (reset),
        .i_state (r_state),
        .i_k     (r_k),
        .i_n     (w_n),
        .o_btu   (w_btu),
        .o_done  (w_done)
    );

    // Frame fields: the stop bit is always the last bit shifted in (MSB), parity
    // sits just below it; data is right-justified below those.
    always_comb begin
        w_stop    = r_shift[9];
        w_par_bit = r_shift[8];
        w_data8   = r_pen ? r_shift[7:0] : r_shift[8:1];
        w_data    = r_eight ? w_data8 : {1'b0, w_data8[7:1]};
        w_perr    = r_pen & (odd_ones(w_data) ^ w_par_bit ^ r_ohel);
    end

    // Receive FSM plus host-side status registers; done is applied one clock
    // after the last sample and takes priority over a coincident READ.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= 19'd0;
            r_eight <= 1'b0;
            r_pen   <= 1'b0;
            r_ohel  <= 1'b0;
            r_shift <= 10'd0;
            r_done  <= 1'b0;
            RX_RDY  <= 1'b0;
            RX_DATA <= 8'd0;
            PERR    <= 1'b0;
            FERR    <= 1'b0;
            OVF     <= 1'b0;
        end else begin
            r_done <= w_done;
            case (r_state)
                IDLE: begin
                    if (!RX) begin
                        r_state <= START;
                        r_k     <= k;
                        r_eight <= EIGHT;
                        r_pen   <= PEN;
                        r_ohel  <= OHEL;
                    end
                end
                START: begin
                    if (w_btu) begin
                        if (!RX) begin
                            r_state <= DATA;
                            r_shift <= 10'd0;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                DATA: begin
                    if (w_btu) begin
                        r_shift <= {RX, r_shift[9:1]};
                        if (w_done) begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase

            if (r_done) begin
                RX_RDY  <= 1'b1;
                RX_DATA <= w_data;
                PERR    <= (READ ? 1'b0 : PERR) | w_perr;
                FERR    <= (READ ? 1'b0 : FERR) | ~w_stop;
                OVF     <= READ ? 1'b0 : (OVF | RX_RDY);
            end else if (READ) begin
                RX_RDY <= 1'b0;
                PERR   <= 1'b0;
                FERR   <= 1'b0;
                OVF    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_receive.sv
// Scoreboard bench for uart_receive: frames push their expected result, a
// per-cycle monitor pops it at the due edge and checks a host-register model.
module tb_uart_receive;

    logic        clk = 1'b0;
    logic        reset;
    logic [18:0] k;
    logic        EIGHT, PEN, OHEL, RX, READ;
    logic        RX_RDY, PERR, FERR, OVF;
    logic [7:0]  RX_DATA;

    always #5 clk = ~clk;

    uart_receive dut (
        .clk     (clk),
        .reset   (reset),
        .k       (k),
        .EIGHT   (EIGHT),
        .PEN     (PEN),
        .OHEL    (OHEL),
        .RX      (RX),
        .READ    (READ),
        .RX_RDY  (RX_RDY),
        .RX_DATA (RX_DATA),
        .PERR    (PERR),
        .FERR    (FERR),
        .OVF     (OVF)
    );

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
        int         due;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    bit   armed = 1'b0;
    logic m_rdy = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovf = 1'b0;
    logic [7:0] m_data = 8'd0;
    logic mon_rd, mon_rs;
    string mon_tag;
    exp_t  mon_e;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    // Monitor: update the host-register model at each edge and compare all outputs.
    initial begin
        forever begin
            @(posedge clk);
            mon_rd = READ;
            mon_rs = reset;
            cyc++;
            #1;
            if (mon_rs) begin
                {m_rdy, m_perr, m_ferr, m_ovf} = 4'b0000;
                m_data = 8'd0;
                q.delete();
                armed = 1'b1;
                mon_tag = "reset";
            end else if (q.size() != 0 && q[0].due == cyc) begin
                mon_e  = q.pop_front();
                m_ovf  = mon_rd ? 1'b0 : (m_ovf | m_rdy);
                m_perr = (mon_rd ? 1'b0 : m_perr) | mon_e.perr;
                m_ferr = (mon_rd ? 1'b0 : m_ferr) | mon_e.ferr;
                m_data = mon_e.data;
                m_rdy  = 1'b1;
                mon_tag = "done";
            end else if (mon_rd) begin
                {m_rdy, m_perr, m_ferr, m_ovf} = 4'b0000;
                mon_tag = "read";
            end else begin
                mon_tag = "hold";
            end
            if (armed) begin
                check_val(mon_tag, {20'd0, RX_RDY, PERR, FERR, OVF, RX_DATA},
                          {20'd0, m_rdy, m_perr, m_ferr, m_ovf, m_data});
            end
        end
    end

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_read();
        READ = 1'b1;
        @(posedge clk);
        #1;
        READ = 1'b0;
    endtask

    task automatic false_start(input logic [18:0] kk);
        k  = kk;
        RX = 1'b0;
        repeat (int'(kk) / 4) @(posedge clk);
        #1;
        RX = 1'b1;
        idle(2 * int'(kk));
    endtask

    // Drives one frame; format inputs are scrambled after the start edge to
    // prove they were latched. chain: stop early so the next start lands on the
    // done-processing edge. abort_at: assert reset at that edge of the frame.
    task automatic send_frame(input logic [7:0] dbyte, input logic eight, input logic pen,
                              input logic ohel, input logic par, input logic stop,
                              input logic [18:0] kk, input logic exp_perr,
                              input bit chain, input bit rd_at_done, input int abort_at);
        int nd, n, half, kk_i, last, due_rel;
        logic [10:0] line;
        exp_t e;
        kk_i = int'(kk);
        nd   = 7 + int'(eight);
        n    = nd + int'(pen) + 1;
        half = kk_i / 2;
        due_rel = half + n * kk_i + 2;
        line = 11'd0;
        for (int j = 0; j < nd; j++) line[1 + j] = dbyte[j];
        if (pen) line[1 + nd] = par;
        line[n] = stop;
        EIGHT = eight; PEN = pen; OHEL = ohel; k = kk;
        RX = 1'b0;
        e.data = eight ? dbyte : {1'b0, dbyte[6:0]};
        e.perr = exp_perr;
        e.ferr = ~stop;
        e.due  = cyc + due_rel;
        q.push_back(e);
        last = chain ? due_rel - 1 : (n + 1) * kk_i;
        for (int i = 1; i <= last; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) begin
                EIGHT = ~eight; PEN = ~pen; OHEL = ~ohel; k = kk + 19'd3;
            end
            if (abort_at != 0 && i == abort_at) begin
                reset = 1'b1;
                RX    = 1'b1;
                @(posedge clk);
                #1;
                reset = 1'b0;
                return;
            end
            if (rd_at_done) READ = (i == due_rel - 1);
            if (i < (n + 1) * kk_i) RX = line[i / kk_i];
        end
    endtask

    initial begin
        reset = 1'b1; RX = 1'b1; READ = 1'b0;
        EIGHT = 1'b1; PEN = 1'b1; OHEL = 1'b0; k = 19'd16;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(5);

        // 8E1, parity wrong then right, READ clears flags but keeps data
        send_frame(8'h93, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 19'd16, 1'b1, 1'b0, 1'b0, 0);
        idle(20); pulse_read(); idle(3);
        send_frame(8'h93, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 19'd16, 1'b0, 1'b0, 1'b0, 0);
        idle(20); pulse_read(); idle(3);

        // 7N1 with a bad stop bit
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 19'd16, 1'b0, 1'b0, 1'b0, 0);
        idle(40); pulse_read(); idle(3);

        // back-to-back overflow, then READ coincident with done
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'd16, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'd16, 1'b0, 1'b1, 1'b0, 0);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'd16, 1'b0, 1'b0, 1'b1, 0);
        idle(20);

        // glitch shorter than half a bit, then a real frame
        false_start(19'd16);
        send_frame(8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 19'd16, 1'b0, 1'b0, 1'b0, 0);
        idle(20); pulse_read(); idle(3);

        // odd k, 7O1 with a parity error
        send_frame(8'h6B, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 19'd5, 1'b1, 1'b0, 1'b0, 0);
        idle(20);

        // reset in mid-DATA, then a clean 8O1 frame
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'd16, 1'b0, 1'b0, 1'b0, 8 + 3 * 16);
        idle(5);
        send_frame(8'hFF, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 19'd16, 1'b0, 1'b0, 1'b0, 0);
        idle(20);

        check_val("queue_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/uart_receive.md
Name: uart_receive

Overview:
- UART serial receiver: samples asynchronous line RX (idle high) at a runtime-programmable bit rate and deserializes one frame.
- Frame format: start bit, then 7 or 8 data bits LSB-first, then an optional parity bit, then one stop bit.
- Presents the received byte plus status flags (ready, parity error, framing error, overflow) to a host-side register/memory interface, which acknowledges with READ.
- Sits between the RX pin synchronizer and the UART's host bus decode.

Parameters:
- none. The bit period and format are run-time inputs.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high.
- k  input  19  clocks per bit period. Must be ≥ 4; the half-bit count is k>>1.
- EIGHT  input  1  1 = 8 data bits, 0 = 7 data bits.
- PEN  input  1  1 = parity bit present.
- OHEL  input  1  parity sense: 1 = odd, 0 = even.
- RX  input  1  serial line, already synchronized to clk.
- READ  input  1  one-clock host acknowledge pulse.
- RX_RDY  output  1  a received byte is waiting.
- RX_DATA  output  8  received byte.
- PERR  output  1  parity error.
- FERR  output  1  framing error (stop bit sampled 0).
- OVF  output  1  a frame completed while RX_RDY was still 1.

Behaviour:
- Reset: synchronous on the clk edge with reset=1. All outputs go to 0, state goes to IDLE, all counters and the shift register clear. Reset mid-frame aborts the frame and produces no flags.
- Format latch: EIGHT, PEN, OHEL and k are latched when leaving IDLE and held for the whole frame.
- Frame length: N = 7 + EIGHT + PEN + 1 bits after the start bit, giving N = 8 to 10.
- IDLE: wait for RX=0. On the first clock with RX=0, go to START and clear the bit-time counter.
- START: count k>>1 clocks, then sample RX.
  - RX=0: valid start. Go to DATA and clear the counters.
  - RX=1: false start. Return to IDLE with no flag change.
- DATA:
  - Sample RX every k clocks; the sample falls at mid-bit.
  - Shift each sample into a 10-bit shift register entering at the MSB, shifting right.
  - After the N-th sample, return to IDLE and pulse the internal done for 1 clock.
- Done processing (registered, visible the clock after the N-th sample):
  - Right-justify the frame into data, parity and stop fields.
  - RX_DATA: 8 data bits, or {1'b0, 7 data bits} when EIGHT=0.
  - PERR (only when PEN=1): set if (XOR of data bits) XOR parity bit XOR OHEL = 1. When PEN=0, PERR is 0 for that frame.
  - FERR: set if the stop sample = 0.
  - OVF: set if RX_RDY=1 at done.
  - RX_RDY: set to 1.
  - RX_DATA is overwritten even on overflow.
- Flag clearing: READ=1 clears RX_RDY, PERR, FERR and OVF on the next edge. RX_DATA holds its value.
- READ coincident with done: done wins. RX_RDY=1; PERR and FERR take the new frame's values; OVF=0, because the host consumed the previous byte.
- Flag stickiness: without READ, PERR, FERR and OVF are sticky and are only OR-ed with the new frame's results.
- Back-to-back frames: a new start is detected from IDLE in the clock immediately after done, whether or not READ has arrived.
- Counter widths: the bit-time counter is 19 bits; the bit counter is 4 bits. With k ≥ 4 there is no wrap.
- Latency from the first RX=0 clock to RX_RDY=1: 1 + (k>>1) + N·k + 1 clocks.

Decomposition:
- Shared package uart_pkg:
  - state enum {IDLE, START, DATA};
  - constant MAX_FRAME_BITS = 10;
  - a function for frame length from EIGHT/PEN.
- One sub-module: uart_bit_timer. It holds the bit-time counter and the bit counter, and produces the `btu` (bit-time-up) and `done` strobes from the state, the latched k and the latched N.

Test Plan:
- k=16, EIGHT=1, PEN=1, OHEL=0. Send start, data bits 1,1,0,0,1,0,0,1 (LSB first), parity 1, stop 1 -> RX_DATA=0x93, RX_RDY=1, PERR=1, FERR=0, OVF=0, with RX_RDY rising 1+8+160+1 clocks after start.
- Same format, parity bit 0 -> PERR=0. Then pulse READ -> RX_RDY=0 next clock, RX_DATA still 0x93.
- EIGHT=0, PEN=0, k=16. Send 0x55 in 7 bits with stop bit 0 -> RX_DATA=0x55, FERR=1, PERR=0.
- Two frames (0xA5, then 0x3C) with no READ in between -> second done gives RX_DATA=0x3C, OVF=1. READ issued in the same clock as a third frame's done -> RX_RDY=1, OVF=0.
- RX low for only k/4 clocks, then high -> no RX_RDY, state back to IDLE; a following valid frame 0x01 is received correctly.
- reset asserted mid-DATA -> all outputs 0 next clock; the next full frame 0xFF (OHEL=1, parity 1, PEN=1) decodes with PERR=0.
